alsu_result_tx: RTL and testbench
=================================

# alsu_result_tx

Downstream consumer of the ALSU's registered 6-bit result bus. It captures result words on a valid strobe into a small FIFO and transmits each word on a single-wire, UART-style serial line: start bit, 6 data bits LSB first, optional even parity, stop bit. It gives the board a way to export ALSU results without routing all six output pins, and reports buffer status and overflow.

## Interface
- `DEPTH`, 4, FIFO depth in words; power of two, ≥2
- `CLKS_PER_BIT`, 4, clock cycles per serial bit; ≥2
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `in_data`  in  6  result word (connects to ALSU `out`)
- `in_valid`  in  1  write strobe, sampled at rising `clk`
- `clr_ovf`  in  1  clears sticky overflow flag
- `tx`  out  1  serial line, idle high, registered
- `busy`  out  1  high while a frame is in progress (FSM not in IDLE)
- `full`  out  1  FIFO level == DEPTH
- `empty`  out  1  FIFO level == 0
- `level`  out  $clog2(DEPTH)+1  current FIFO occupancy
- `ovf`  out  1  sticky: a write was dropped

## Operation
- FIFO: circular buffer with read/write pointers of width $clog2(DEPTH); both pointers wrap modulo DEPTH.
- Push occurs when `in_valid` && (!`full` || pop in the same cycle). Simultaneous push and pop: `level` unchanged, and the push is accepted even at full.
- `in_valid` while `full` with no pop: the word is dropped and `ovf` is set. `ovf` holds until `clr_ovf`. If the set and the clear happen in the same cycle, the set wins.
- FSM states: IDLE, START, DATA, PARITY, STOP. A bit counter (0..CLKS_PER_BIT-1) times each bit. An index counter (0..5) walks the data bits.
- IDLE: `tx`=1. If !`empty`, pop the head word into the shift register and go to START.
- START: `tx`=0 for one bit time, then go to DATA.
- DATA: `tx`=shift[0] for one bit time, then shift right. After 6 bits, go to PARITY, or go to STOP if parity is compiled out.
- PARITY: `tx`=^word (even parity) for one bit time, then go to STOP.
- STOP: `tx`=1 for one bit time. On the last cycle of STOP:
  - if !`empty`, pop and go directly to START (no idle gap);
  - otherwise go to IDLE.
- The word in flight is held in the shift register. Pushes during a frame never disturb it.
- Reset (asserted, any state, including mid-frame):
  - FSM goes to IDLE; `tx`=1; pointers, `level` and counters go to 0; `ovf`=0.
  - `empty`=1, `full`=0, `busy`=0.
  - Contents of the partial frame are discarded, and the line returns high immediately.

## Timing
- All outputs are registered. The reset values are listed above.
- Write at edge E0 into an empty FIFO with IDLE: the pop happens at E1, and `tx` falls after E1.
- Frame length: 9 bit times (9·CLKS_PER_BIT cycles) with parity, 8 without.
- Back-to-back frames: the stop bit of frame N is followed immediately by the start bit of frame N+1.
- `level`, `full` and `empty` update on the edge that performs the push or pop.
- `busy` rises on the edge that enters START and falls on the edge that enters IDLE.

## Configuration
- `ALSU_TX_PARITY_EN` defined: PARITY state present; 9-bit-time frames with an even-parity bit after data bit 5.
- Not defined: PARITY state and its logic are removed; DATA goes directly to STOP; 8-bit-time frames.

## Test plan
Benches use DEPTH=4 and CLKS_PER_BIT=4.
- Single word 6'b101101 into an idle block, parity on:
  - `tx` sequence per 4 cycles is 0,1,0,1,1,0,1,0,1.
  - `busy` is high for 36 cycles, then `empty`=1.
  - Parity off: 0,1,0,1,1,0,1,1 over 32 cycles.
- `in_valid` on 6 consecutive edges E0..E5 with words 1..6, idle start:
  - word 1 is popped at E1;
  - `level` reads 1,1,2,3,4;
  - word 6 is dropped and `ovf`=1;
  - the line then carries 1,2,3,4,5 back-to-back with no idle cycles.
- With `ovf`=1, pulse `clr_ovf` alone → `ovf`=0 next cycle. Pulse `clr_ovf` together with an overflowing write → `ovf` stays 1.
- FIFO full, with a write on the same cycle as the STOP-end pop → the word is accepted, `level` stays 4, and `ovf` stays 0.
- Assert `rst` low during data bit 3 of a frame with 2 words queued:
  - `tx`=1 immediately, with `level`=0, `empty`=1, `busy`=0 and `ovf`=0.
  - After release, no frame is sent until a new write.

Source files
------------

// File: rtl/alsu_result_tx.sv
// alsu_result_tx: buffers 6-bit ALSU result words in a small FIFO and sends each one
// as a UART-style frame (start, 6 data LSB first, optional even parity, stop). Parity bit: ALSU_TX_PARITY_EN.
`timescale 1ns/1ps
module alsu_result_tx #(
  parameter int DEPTH        = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [5:0]               in_data,
  input  logic                     in_valid,
  input  logic                     clr_ovf,
  output logic                     tx,
  output logic                     busy,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef ALSU_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  logic [5:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          full_q, full_d, empty_q, empty_d, ovf_q, ovf_d;
  logic          tx_q, tx_d, busy_q, busy_d;
  state_t        state_q, state_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [5:0]    shift_q, shift_d;
`ifdef ALSU_TX_PARITY_EN
  logic          par_q, par_d;
`endif
  logic          pop, push, drop, bit_last;

  assign bit_last = (bit_cnt_q == CW'(CLKS_PER_BIT - 1));

  // Frame sequencer; pop is raised only when a new frame is loaded.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
`ifdef ALSU_TX_PARITY_EN
    par_d     = par_q;
`endif
    pop       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty_q) begin
          pop       = 1'b1;
          state_d   = START;
          bit_cnt_d = '0;
        end
      end
      START: begin
        if (bit_last) begin
          state_d   = DATA;
          bit_cnt_d = '0;
          idx_d     = 3'd0;
        end else begin
          bit_cnt_d = bit_cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (bit_last) begin
          bit_cnt_d = '0;
          shift_d   = shift_q >> 1;
          if (idx_q == 3'd5) begin
`ifdef ALSU_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + CW'(1);
        end
      end
`ifdef ALSU_TX_PARITY_EN
      PARITY: begin
        if (bit_last) begin
          state_d   = STOP;
          bit_cnt_d = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + CW'(1);
        end
      end
`endif
      STOP: begin
        if (bit_last) begin
          bit_cnt_d = '0;
          if (!empty_q) begin
            pop     = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      shift_d = mem_q[rd_ptr_q];
`ifdef ALSU_TX_PARITY_EN
      par_d   = ^mem_q[rd_ptr_q];
`endif
    end
  end

  // Line level is derived from the upcoming state so tx itself is a flop.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef ALSU_TX_PARITY_EN
      PARITY:  tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  // A write at full is still taken when the same edge frees a slot.
  always_comb begin
    push     = in_valid && (!full_q || pop);
    drop     = in_valid && !push;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    full_d  = (level_d == LW'(DEPTH));
    empty_d = (level_d == '0);
    ovf_d   = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
`ifdef ALSU_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      ovf_q     <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
`ifdef ALSU_TX_PARITY_EN
      par_q     <= par_d;
`endif
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      ovf_q     <= ovf_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  assign tx    = tx_q;
  assign busy  = busy_q;
  assign full  = full_q;
  assign empty = empty_q;
  assign level = level_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_alsu_result_tx.sv
// tb_alsu_result_tx: random and directed stimulus against a queue-based reference model;
// a serial-line monitor decodes frames and checks them against a scoreboard of expected words.
`timescale 1ns/1ps
module tb_alsu_result_tx;
  localparam int DEPTH = 4;
  localparam int CPB   = 4;
`ifdef ALSU_TX_PARITY_EN
  localparam int NB = 9;
  localparam logic [8:0] PAT = 9'b101011010;
`else
  localparam int NB = 8;
  localparam logic [8:0] PAT = 9'b011011010;
`endif
  localparam int FRAME = NB * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       clr_ovf = 1'b0;
  logic [5:0] in_data = '0;
  logic       tx, busy, full, empty, ovf;
  logic [2:0] level;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [5:0] word;
    int         start;
  } frame_t;

  // Reference model: FIFO contents, cycles left in the current frame, sticky overflow.
  logic [5:0] mq[$];
  frame_t     eq[$];
  int         rem = 0;
  logic       m_ovf = 1'b0;
  bit         m_pop, m_push;
  frame_t     m_fr;

  bit         mon_act = 1'b0;
  bit         mon_has;
  int         mon_off;
  logic [8:0] mon_bits;
  frame_t     mon_exp;

  int   n, busy_cnt, low_cnt;
  logic t1_tx[64];
  int   lv_exp[5] = '{1, 1, 2, 3, 4};

  alsu_result_tx #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .clr_ovf  (clr_ovf),
    .tx       (tx),
    .busy     (busy),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic logic [8:0] frame_bits(input logic [5:0] w);
    logic [8:0] f;
`ifdef ALSU_TX_PARITY_EN
    f = {1'b1, ^w, w, 1'b0};
`else
    f = {1'b0, 1'b1, w, 1'b0};
`endif
    return f;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      eq.delete();
      rem   = 0;
      m_ovf = 1'b0;
    end else begin
      if (rem > 0) rem--;
      m_pop  = (rem == 0) && (mq.size() > 0);
      m_push = in_valid && ((mq.size() < DEPTH) || m_pop);
      if (m_pop) begin
        m_fr.word  = mq.pop_front();
        m_fr.start = cyc + 1;
        eq.push_back(m_fr);
        rem = FRAME;
      end
      if (m_push) mq.push_back(in_data);
      if (in_valid && !m_push) m_ovf = 1'b1;
      else if (clr_ovf) m_ovf = 1'b0;
    end
  end

  // Status outputs every cycle.
  always @(negedge clk) begin
    check("level", level, mq.size());
    check("full", full, mq.size() == DEPTH);
    check("empty", empty, mq.size() == 0);
    check("busy", busy, rem > 0);
    check("ovf", ovf, m_ovf);
  end

  // Serial monitor: samples mid-bit and compares each frame against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      mon_act = 1'b0;
    end else if (!mon_act) begin
      if (tx === 1'b0) begin
        mon_act  = 1'b1;
        mon_off  = 0;
        mon_bits = '0;
        mon_has  = eq.size() > 0;
        if (!mon_has) begin
          checks++;
          failures++;
          $display("FAIL unexpected_frame at cycle %0d: got start bit, expected idle line", cyc);
        end else begin
          mon_exp = eq.pop_front();
          check("frame_start", cyc, mon_exp.start);
        end
      end
    end else begin
      mon_off++;
      if (mon_off % CPB == CPB / 2) mon_bits[mon_off / CPB] = tx;
      if (mon_off == (NB - 1) * CPB + CPB / 2) begin
        mon_act = 1'b0;
        if (mon_has) check("frame_bits", mon_bits, frame_bits(mon_exp.word));
      end
    end
  end

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (!(mq.size() == 0 && rem == 0 && eq.size() == 0 && !mon_act) && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("drain_done", k < budget, 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_empty", empty, 1);
    check("rst_busy", busy, 0);
    #1 rst = 1'b1;

    // Single word 101101 from idle.
    @(negedge clk);
    in_data  = 6'b101101;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      t1_tx[i] = tx;
      busy_cnt += int'(busy);
      @(negedge clk);
    end
    check("t1_idle_before_pop", t1_tx[0], 1);
    for (int k = 0; k < NB; k++) check("t1_bit", t1_tx[1 + k * CPB + CPB / 2], PAT[k]);
    check("t1_busy_cycles", busy_cnt, FRAME);
    check("t1_empty", empty, 1);

    // Six consecutive writes of 1..6; the sixth overflows.
    for (int i = 0; i < 6; i++) begin
      in_data  = 6'(i + 1);
      in_valid = 1'b1;
      @(negedge clk);
      if (i < 5) check("burst_level", level, lv_exp[i]);
    end
    in_valid = 1'b0;
    check("burst_ovf", ovf, 1);
    check("burst_full", full, 1);
    wait_idle(400);

    // Clear alone, then set and clear together.
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    check("clr_ovf_alone", ovf, 0);
    for (int i = 0; i < 6; i++) begin
      in_data  = 6'($urandom);
      in_valid = 1'b1;
      @(negedge clk);
    end
    check("fill_ovf", ovf, 1);
    in_data = 6'($urandom);
    clr_ovf = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    clr_ovf  = 1'b0;
    check("set_beats_clear", ovf, 1);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    check("clr_before_full_pop", ovf, 0);

    // Write while full on the edge that ends STOP.
    n = 0;
    while (!(rem == 1 && mq.size() == DEPTH) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("found_stop_end", n < 200, 1);
    in_data  = 6'($urandom);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("full_pop_push_level", level, 4);
    check("full_pop_push_ovf", ovf, 0);
    wait_idle(800);

    // Reset during data bit 3 with two words queued.
    in_data  = 6'b000111;
    in_valid = 1'b1;
    @(negedge clk);
    in_data = 6'($urandom);
    @(negedge clk);
    in_data = 6'($urandom);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4 * CPB) @(negedge clk);
    check("pre_rst_level", level, 2);
    check("pre_rst_tx_bit3", tx, 0);
    #1 rst = 1'b0;
    #1;
    check("rst_mid_tx", tx, 1);
    check("rst_mid_level", level, 0);
    check("rst_mid_empty", empty, 1);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_ovf", ovf, 0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    low_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) low_cnt++;
    end
    check("post_rst_silent", low_cnt, 0);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      in_valid = ($urandom_range(0, 99) < 12);
      in_data  = 6'($urandom);
      clr_ovf  = ($urandom_range(0, 99) < 4);
      @(negedge clk);
    end
    in_valid = 1'b0;
    clr_ovf  = 1'b0;
    wait_idle(1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
